// File: rtl/seq_gen_tx.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first, repeated repeat+1 times.
// Optional macro SEQ_GEN_GAP_EN inserts one idle GAP cycle between consecutive repetitions.
module seq_gen_tx #(
    parameter int PAT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_start,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic [3:0]       i_pat_len,
    input  logic [3:0]       i_repeat,
    output logic             o_sequence_out,
    output logic             o_bit_valid,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [4:0] PAT_W_L = 5'(PAT_W);

`ifdef SEQ_GEN_GAP_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2,
        S_GAP   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;
`endif

    state_t           r_state;
    logic [PAT_W-1:0] r_pattern;
    logic [4:0]       r_len;
    logic [4:0]       r_idx;
    logic [3:0]       r_rep;
    logic             r_seq;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic [4:0]       w_cap_len;
    logic             w_first_bit;
    logic             w_next_bit;
    logic             w_restart_bit;
    logic             w_accept;

    // Selects one bit of a pattern by a 5-bit index; out-of-range indices read as 0.
    function automatic logic sel_bit(input logic [PAT_W-1:0] pat, input logic [4:0] idx);
        logic b;
        b = 1'b0;
        for (int k = 0; k < PAT_W; k++) begin
            if (idx == 5'(k)) begin
                b = pat[k];
            end
        end
        return b;
    endfunction

    // Length 0 or anything wider than the pattern register means "use the full register".
    assign w_cap_len     = ((i_pat_len == 4'd0) || ({1'b0, i_pat_len} > PAT_W_L)) ? PAT_W_L
                                                                                  : {1'b0, i_pat_len};
    assign w_first_bit   = sel_bit(i_pattern, w_cap_len - 5'd1);
    assign w_next_bit    = sel_bit(r_pattern, r_idx - 5'd1);
    assign w_restart_bit = sel_bit(r_pattern, r_len - 5'd1);
    assign w_accept      = i_start;

    // Transmit FSM; r_idx tracks the index of the bit currently on the output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pattern <= '0;
            r_len     <= 5'd0;
            r_idx     <= 5'd0;
            r_rep     <= 4'd0;
            r_seq     <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_state   <= S_SHIFT;
                        r_pattern <= i_pattern;
                        r_len     <= w_cap_len;
                        r_idx     <= w_cap_len - 5'd1;
                        r_rep     <= i_repeat;
                        r_seq     <= w_first_bit;
                        r_valid   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                    end else begin
                        r_state   <= S_IDLE;
                        r_seq     <= 1'b0;
                        r_valid   <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (r_idx != 5'd0) begin
                        r_idx <= r_idx - 5'd1;
                        r_seq <= w_next_bit;
                    end else if (r_rep != 4'd0) begin
                        r_rep <= r_rep - 4'd1;
`ifdef SEQ_GEN_GAP_EN
                        r_state <= S_GAP;
                        r_seq   <= 1'b0;
                        r_valid <= 1'b0;
`else
                        r_idx   <= r_len - 5'd1;
                        r_seq   <= w_restart_bit;
`endif
                    end else begin
                        r_state <= S_DONE;
                        r_seq   <= 1'b0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
`ifdef SEQ_GEN_GAP_EN
                S_GAP: begin
                    r_state <= S_SHIFT;
                    r_idx   <= r_len - 5'd1;
                    r_seq   <= w_restart_bit;
                    r_valid <= 1'b1;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_seq   <= 1'b0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_sequence_out = r_seq;
    assign o_bit_valid    = r_valid;
    assign o_busy         = r_busy;
    assign o_done         = r_done;

endmodule

// File: doc/seq_gen_tx.md
SEQ_GEN_TX -- requirements
Module: seq_gen_tx

Interface
REQ-001 Parameter PAT_W, default 8: width of the pattern register, in bits.
REQ-002 clock  input  1  rising-edge clock for all sequential logic.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to transmit; sampled on rising clock edges.
REQ-005 pattern  input  PAT_W  bits to transmit; transmitted MSB-first starting from bit pat_len-1.
REQ-006 pat_len  input  4  number of pattern bits per repetition.
REQ-007 repeat  input  4  number of extra repetitions; total repetitions = repeat+1.
REQ-008 sequence_out  output  1  serial data bit.
REQ-009 bit_valid  output  1  high when sequence_out carries a pattern bit.
REQ-010 busy  output  1  high while a transmission is in progress.
REQ-011 done  output  1  one-cycle pulse after the final bit.

Function
REQ-012 The FSM SHALL use the states IDLE, SHIFT, GAP and DONE; GAP SHALL exist only when SEQ_GEN_GAP_EN is defined.
REQ-013 All outputs SHALL be registered; no output SHALL depend combinationally on an input.
REQ-014 In IDLE or DONE, start=1 at an edge SHALL capture pattern, pat_len and repeat, and SHALL enter SHIFT.
REQ-015 The first bit, pattern[pat_len-1], SHALL appear with bit_valid=1 in the cycle immediately after the accepting edge.
REQ-016 SHIFT SHALL emit one bit per cycle, in descending bit index, down to bit 0.
REQ-017 pat_len values of 0 and of values greater than PAT_W SHALL be clamped to PAT_W at capture.
REQ-018 After bit 0, if repetitions remain, the block SHALL restart at bit pat_len-1:
- without the macro: on the next cycle;
- with the macro: via GAP.
REQ-019 After bit 0 of the final repetition, the block SHALL enter DONE for exactly one cycle with done=1, bit_valid=0 and busy=0, and SHALL then go to IDLE unless start=1.
REQ-020 start=1 during DONE SHALL be accepted, giving back-to-back transmissions with no IDLE cycle between them.
REQ-021 busy SHALL be 1 in SHIFT and GAP, and 0 in IDLE and DONE.
REQ-022 start SHALL be ignored while busy=1; captured values SHALL be unaffected by input changes during a transmission.
REQ-023 sequence_out SHALL be 0 whenever bit_valid=0.
REQ-024 The bit index and the repetition counter SHALL be sized so that no wrap-around occurs for PAT_W up to 16 and repeat=15.

Reset
REQ-025 Asserting reset SHALL immediately force IDLE, with sequence_out=0, bit_valid=0, busy=0 and done=0.
REQ-026 Reset asserted mid-transmission SHALL discard all remaining bits and SHALL NOT produce a done pulse.
REQ-027 After reset is released, the first accepted start SHALL behave exactly as after power-up.

Configuration
REQ-028 Macro SEQ_GEN_GAP_EN, when defined, SHALL insert one GAP cycle between consecutive repetitions, with bit_valid=0, sequence_out=0 and busy=1.
REQ-029 Without SEQ_GEN_GAP_EN, repetitions SHALL be contiguous, and GAP logic SHALL be absent.
REQ-030 Neither setting SHALL change first-bit latency or done timing relative to the final bit.

Verification
REQ-031 pattern=8'h0B, pat_len=4, repeat=0, start pulsed -> sequence_out 1,0,1,1 with bit_valid=1 for 4 cycles; done=1 on the 5th cycle; busy=1 for cycles 1-4.
REQ-032 pattern=8'h0B, pat_len=4, repeat=2 -> without macro: 101110111011 (12 valid cycles); with macro: 1011,gap,1011,gap,1011 (14 cycles; bit_valid=0 in cycles 5 and 10); then done.
REQ-033 pat_len=0, pattern=8'hA5 -> 8 bits emitted: 1,0,1,0,0,1,0,1; then done.
REQ-034 start held high through the whole transmission, with pattern changed mid-stream -> the first transmission is unaffected; a second transmission starts in the cycle after DONE with the new pattern; done pulses once per transmission.
REQ-035 reset asserted after the 2nd bit of 8'h0B/pat_len=4 -> outputs go to 0 immediately; no done pulse; a subsequent start emits 1,0,1,1 normally.
